// File: rtl/line_raster_gen_pkg.sv
// Shared types and constants for the Bresenham line rasterizer.
// Coordinates are signed Q10; the integer pixel part occupies the top INT_W bits.
package line_raster_gen_pkg;

    localparam int COORD_W    = 21;
    localparam int COORD_FRAC = 10;
    localparam int INT_W      = COORD_W - COORD_FRAC;
    localparam int ERR_W      = INT_W + 2;
    localparam int E2_W       = ERR_W + 1;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [INT_W-1:0]   icoord_t;
    typedef logic signed [ERR_W-1:0]   err_t;
    typedef logic signed [E2_W-1:0]    e2_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        EMIT
    } state_t;

    function automatic coord_t to_q(input icoord_t v);
        return coord_t'({v, {COORD_FRAC{1'b0}}});
    endfunction

endpackage

// File: rtl/line_raster_gen_if.sv
// Command and pixel streams of the line rasterizer.
// The slave modport is the rasterizer; the master modport is its client.
interface line_raster_gen_if
    import line_raster_gen_pkg::*;
;
    logic   cmd_valid;
    logic   cmd_ready;
    coord_t vtxA_X;
    coord_t vtxA_Y;
    coord_t vtxB_X;
    coord_t vtxB_Y;
    logic   pix_valid;
    logic   pix_ready;
    coord_t pix_X;
    coord_t pix_Y;
    logic   pix_last;
    logic   done;

    modport master (
        output cmd_valid, vtxA_X, vtxA_Y, vtxB_X, vtxB_Y, pix_ready,
        input  cmd_ready, pix_valid, pix_X, pix_Y, pix_last, done
    );

    modport slave (
        input  cmd_valid, vtxA_X, vtxA_Y, vtxB_X, vtxB_Y, pix_ready,
        output cmd_ready, pix_valid, pix_X, pix_Y, pix_last, done
    );

endinterface

// File: rtl/line_raster_gen_bresenham_step.sv
// One combinational Bresenham advance: both axis decisions use the incoming err,
// so a diagonal step applies dy and dx in the same cycle.
module bresenham_step
    import line_raster_gen_pkg::*;
(
    input  err_t    i_err,
    input  icoord_t i_x,
    input  icoord_t i_y,
    input  logic    i_sx_neg,
    input  logic    i_sy_neg,
    input  err_t    i_dx,
    input  err_t    i_dy,
    output err_t    o_err,
    output icoord_t o_x,
    output icoord_t o_y
);

    e2_t  w_e2;
    logic w_step_x;
    logic w_step_y;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_e2     = e2_t'(i_err) <<< 1;
        w_step_x = (w_e2 >= e2_t'(i_dy));
        w_step_y = (w_e2 <= e2_t'(i_dx));
        o_err    = i_err;
        o_x      = i_x;
        o_y      = i_y;
        if (w_step_x) begin
            o_err = o_err + i_dy;
            o_x   = i_sx_neg ? (i_x - icoord_t'(1)) : (i_x + icoord_t'(1));
        end
        if (w_step_y) begin
            o_err = o_err + i_dx;
            o_y   = i_sy_neg ? (i_y - icoord_t'(1)) : (i_y + icoord_t'(1));
        end
    end

endmodule

// File: rtl/line_raster_gen.sv
// Bresenham line rasterizer: accepts a Q10 segment A->B and streams every
// covered pixel, A first and B last, one per cycle over a valid/ready port.
module line_raster_gen
    import line_raster_gen_pkg::*;
#(
    parameter int W    = COORD_W,
    parameter int FRAC = COORD_FRAC
) (
    input logic              clk,
    input logic              rst,
    line_raster_gen_if.slave bus
);

    state_t  r_state;
    state_t  w_next_state;

    icoord_t r_x0, r_y0, r_x1, r_y1;
    icoord_t r_x, r_y;
    err_t    r_dx, r_dy, r_err;
    logic    r_sx_neg, r_sy_neg;
    logic    r_done;

    logic    w_cmd_ready;
    logic    w_pix_valid;
    logic    w_at_end;
    logic    w_cmd_fire;
    logic    w_advance;
    logic    w_finish;

    err_t    w_ddx, w_ddy, w_adx, w_ady;
    err_t    w_err_n;
    icoord_t w_x_n, w_y_n;

    // Sign differences in ERR_W bits so the magnitude of a full-range span fits.
    always_comb begin
        w_ddx = err_t'(r_x1) - err_t'(r_x0);
        w_ddy = err_t'(r_y1) - err_t'(r_y0);
        w_adx = w_ddx[ERR_W-1] ? -w_ddx : w_ddx;
        w_ady = w_ddy[ERR_W-1] ? -w_ddy : w_ddy;
    end

    bresenham_step u_step (
        .i_err    (r_err),
        .i_x      (r_x),
        .i_y      (r_y),
        .i_sx_neg (r_sx_neg),
        .i_sy_neg (r_sy_neg),
        .i_dx     (r_dx),
        .i_dy     (r_dy),
        .o_err    (w_err_n),
        .o_x      (w_x_n),
        .o_y      (w_y_n)
    );

    assign w_at_end = (r_x == r_x1) && (r_y == r_y1);

    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_pix_valid  = 1'b0;
        w_cmd_fire   = 1'b0;
        w_advance    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = !rst;
                w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
                if (w_cmd_fire) w_next_state = SETUP;
            end
            SETUP: w_next_state = EMIT;
            EMIT: begin
                w_pix_valid = 1'b1;
                w_advance   = bus.pix_ready && !w_at_end;
                w_finish    = bus.pix_ready && w_at_end;
                if (w_finish) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_cmd_fire) begin
                // Arithmetic shift of Q10 is just the integer slice: floor toward -inf.
                r_x0 <= bus.vtxA_X[W-1:FRAC];
                r_y0 <= bus.vtxA_Y[W-1:FRAC];
                r_x1 <= bus.vtxB_X[W-1:FRAC];
                r_y1 <= bus.vtxB_Y[W-1:FRAC];
            end
            if (r_state == SETUP) begin
                r_dx     <= w_adx;
                r_dy     <= -w_ady;
                r_err    <= w_adx - w_ady;
                r_sx_neg <= !(r_x0 < r_x1);
                r_sy_neg <= !(r_y0 < r_y1);
                r_x      <= r_x0;
                r_y      <= r_y0;
            end
            if (w_advance) begin
                r_err <= w_err_n;
                r_x   <= w_x_n;
                r_y   <= w_y_n;
            end
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.pix_valid = w_pix_valid;
    assign bus.pix_X     = to_q(r_x);
    assign bus.pix_Y     = to_q(r_y);
    assign bus.pix_last  = w_pix_valid && w_at_end;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_line_raster_gen.sv
// Directed bench for line_raster_gen: expected pixels are queued per command
// and popped at each accepted handshake.
module tb_line_raster_gen;
    import line_raster_gen_pkg::*;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   last;
    } pix_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    pix_t exp_q[$];

    line_raster_gen_if bus ();

    line_raster_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pix(input int xi, input int yi, input bit last);
        pix_t p;
        p.x    = coord_t'(xi * 1024);
        p.y    = coord_t'(yi * 1024);
        p.last = last;
        exp_q.push_back(p);
    endtask

    task automatic send_cmd(input coord_t ax, input coord_t ay, input coord_t bx, input coord_t by);
        int guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_wait", int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.vtxA_X = ax;
        bus.vtxA_Y = ay;
        bus.vtxB_X = bx;
        bus.vtxB_Y = by;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.vtxA_X = coord_t'($urandom);
        bus.vtxA_Y = coord_t'($urandom);
        bus.vtxB_X = coord_t'($urandom);
        bus.vtxB_Y = coord_t'($urandom);
    endtask

    // Called right after send_cmd; stalls pixel stall_idx for stall_len cycles
    // and returns early once abort_after pixels have been accepted (-1: never).
    task automatic collect(input string tag, input int stall_idx, input int stall_len, input int abort_after);
        int   lat = 1;
        int   idx = 0;
        int   budget = 0;
        int   stall_left = stall_len;
        bit   finished = 0;
        bit   saw_last = 0;
        pix_t held;
        pix_t p;
        @(negedge clk);
        while (!bus.pix_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
        while (1) begin
            if (bus.pix_valid) begin
                if (idx == stall_idx && stall_left > 0) begin
                    if (stall_left == stall_len) begin
                        held.x = bus.pix_X;
                        held.y = bus.pix_Y;
                        held.last = bus.pix_last;
                    end else begin
                        check({tag, "_hold_x"}, int'(bus.pix_X), int'(held.x));
                        check({tag, "_hold_y"}, int'(bus.pix_Y), int'(held.y));
                        check({tag, "_hold_last"}, int'(bus.pix_last), int'(held.last));
                    end
                    bus.pix_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.pix_ready = 1'b1;
                    if (exp_q.size() == 0) begin
                        check({tag, "_extra_pixel"}, int'(bus.pix_X), -1);
                        finished = 1;
                    end else begin
                        p = exp_q.pop_front();
                        check($sformatf("%s_x%0d", tag, idx), int'(bus.pix_X), int'(p.x));
                        check($sformatf("%s_y%0d", tag, idx), int'(bus.pix_Y), int'(p.y));
                        check($sformatf("%s_last%0d", tag, idx), int'(bus.pix_last), int'(p.last));
                        idx++;
                        if (bus.pix_last) begin
                            finished = 1;
                            saw_last = 1;
                        end
                        if (idx == abort_after) finished = 1;
                    end
                end
            end
            if (finished) break;
            @(negedge clk);
            budget++;
            if (budget > 200) begin
                n_tests++;
                n_fail++;
                $error("FAIL %s_timeout: observed no last pixel after %0d cycles, expected completion", tag, budget);
                break;
            end
        end
        if (saw_last) begin
            check({tag, "_queue_empty"}, exp_q.size(), 0);
            @(negedge clk);
            check({tag, "_done"}, int'(bus.done), 1);
            check({tag, "_valid_off"}, int'(bus.pix_valid), 0);
            check({tag, "_cmd_ready"}, int'(bus.cmd_ready), 1);
            @(negedge clk);
            check({tag, "_done_pulse"}, int'(bus.done), 0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.pix_ready = 1'b1;
        bus.vtxA_X    = '0;
        bus.vtxA_Y    = '0;
        bus.vtxB_X    = '0;
        bus.vtxB_Y    = '0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", int'(bus.cmd_ready), 0);
        check("rst_pix_valid", int'(bus.pix_valid), 0);
        check("rst_pix_last", int'(bus.pix_last), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_pix_x", int'(bus.pix_X), 0);
        check("rst_pix_y", int'(bus.pix_Y), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", int'(bus.cmd_ready), 1);

        // Horizontal line.
        for (int i = 0; i < 5; i++) push_pix(i, 0, i == 4);
        send_cmd(21'h0, 21'h0, 21'h1000, 21'h0);
        collect("horiz", -1, 0, -1);

        // Steep line.
        push_pix(0, 0, 0); push_pix(0, 1, 0); push_pix(1, 2, 0);
        push_pix(1, 3, 0); push_pix(2, 4, 0); push_pix(2, 5, 1);
        send_cmd(21'h0, 21'h0, 21'h800, 21'h1400);
        collect("steep", -1, 0, -1);

        // Negative direction.
        for (int i = 3; i >= 0; i--) push_pix(i, i, i == 0);
        send_cmd(21'hC00, 21'hC00, 21'h0, 21'h0);
        collect("neg", -1, 0, -1);

        // Fractional parts floor to the same pixel.
        push_pix(1, 7, 1);
        send_cmd(21'h5FF, 21'h1C00, 21'h400, 21'h1FFF);
        collect("degen_frac", -1, 0, -1);

        push_pix(7, -2, 1);
        send_cmd(21'h1C00, 21'h1FF800, 21'h1C00, 21'h1FF800);
        collect("degen_neg", -1, 0, -1);

        // Steep line again with pixel (0,1) held off for 3 cycles.
        push_pix(0, 0, 0); push_pix(0, 1, 0); push_pix(1, 2, 0);
        push_pix(1, 3, 0); push_pix(2, 4, 0); push_pix(2, 5, 1);
        send_cmd(21'h0, 21'h0, 21'h800, 21'h1400);
        collect("stall", 1, 3, -1);

        // Shallow line crossing zero in both axes: (-3,2) -> (4,-1).
        push_pix(-3, 2, 0); push_pix(-2, 2, 0); push_pix(-1, 1, 0); push_pix(0, 1, 0);
        push_pix(1, 0, 0);  push_pix(2, 0, 0);  push_pix(3, -1, 0); push_pix(4, -1, 1);
        send_cmd(coord_t'(-3 * 1024), coord_t'(2 * 1024), coord_t'(4 * 1024), coord_t'(-1 * 1024));
        collect("mixed", -1, 0, -1);

        // Reset in the middle of the horizontal line, after its 2nd pixel.
        for (int i = 0; i < 5; i++) push_pix(i, 0, i == 4);
        send_cmd(21'h0, 21'h0, 21'h1000, 21'h0);
        collect("abort", -1, 0, 2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_pix_valid", int'(bus.pix_valid), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_cmd_ready_in_rst", int'(bus.cmd_ready), 0);
        rst = 1'b0;
        #1;
        check("abort_cmd_ready", int'(bus.cmd_ready), 1);
        @(negedge clk);
        check("abort_no_done", int'(bus.done), 0);
        check("abort_still_idle", int'(bus.pix_valid), 0);
        exp_q.delete();

        for (int i = 3; i >= 0; i--) push_pix(i, i, i == 0);
        send_cmd(21'hC00, 21'hC00, 21'h0, 21'h0);
        collect("after_abort", -1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_raster_gen.md
Name: line_raster_gen

Overview:
Bresenham line rasterizer. Takes a segment A→B in the shared Q10 vertex format (21-bit signed, 10 fractional bits) and emits every covered pixel coordinate, one per cycle, over a valid/ready stream. It is the push-side counterpart to the per-pixel on-segment tester. The tester answers "is this scan pixel on AB?"; this block generates the pixel list of AB, for the wireframe draw path that writes pixels into the framebuffer.

Parameters:
W, 21, coordinate width (signed, Q-format) for inputs and outputs
FRAC, 10, fractional bits; integer pixel part is [W-1:FRAC]

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
cmd_valid  in  1  segment command valid
cmd_ready  out  1  block can accept a command (IDLE only)
vtxA_X, vtxA_Y  in  W  start vertex, signed Q10
vtxB_X, vtxB_Y  in  W  end vertex, signed Q10
pix_valid  out  1  pix_X/pix_Y hold a pixel
pix_ready  in  1  downstream accepts the pixel
pix_X, pix_Y  out  W  pixel coordinate, signed Q10, fraction bits always 0
pix_last  out  1  qualifies pix_valid; set on the final pixel (B)
done  out  1  one-cycle pulse after the last pixel handshake

Behaviour:
- Reset values: cmd_ready=0 while rst is high and 1 in the first cycle after it drops; pix_valid=0, pix_last=0, done=0, pix_X=pix_Y=0. State is IDLE.
- States: IDLE → SETUP → EMIT → IDLE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
  - Latch x0=A_X>>>FRAC, y0=A_Y>>>FRAC, x1, y1 (floor; fractions are discarded).
  - Go to SETUP.
- SETUP, one cycle:
  - dx=|x1-x0|, dy=-|y1-y0|.
  - sx=+1 if x0<x1 else -1; sy likewise.
  - err=dx+dy.
  - Integer coordinates are 11 bits; dx, dy and err use 13 bits signed; e2=2*err uses 14 bits signed, with no overflow for any legal input.
  - Drive the first pixel (x0,y0) and assert pix_valid. Go to EMIT.
- EMIT:
  - pix_X={x,FRAC'b0}, pix_Y={y,FRAC'b0}, sign-extended to W.
  - pix_last=(x==x1 && y==y1).
  - On pix_valid&&pix_ready with !pix_last, advance in a single cycle:
    - e2=2*err.
    - If e2>=dy: err+=dy, x+=sx.
    - If e2<=dx: err+=dx, y+=sy.
    - Both updates use the pre-update err.
  - On pix_valid&&pix_ready with pix_last: next cycle pix_valid=0, done=1 for one cycle, state IDLE, cmd_ready=1.
- Throughput: with pix_ready held high, one pixel per cycle. First pix_valid appears 2 cycles after the command handshake.
- Pixel count is max(|x1-x0|,|y1-y0|)+1. The first pixel is A and the last is B.
- Backpressure: while pix_valid&&!pix_ready, pix_X, pix_Y and pix_last stay stable and no internal state changes.
- Degenerate A==B (after floor): exactly one pixel, with pix_last=1.
- Vertex inputs are sampled only at the command handshake; changes during SETUP/EMIT are ignored. cmd_valid during busy states is not accepted (cmd_ready=0).
- rst asserted mid-line: on the next edge the block returns to IDLE, pix_valid=0, done=0; the remaining pixels are discarded and there is no done pulse.
- Invariant: every emitted pixel lies inside the floored bounding box of A and B, and consecutive pixels differ by at most 1 in each axis.

Decomposition:
- Shared package (gpu_pkg): COORD_W=21, COORD_FRAC=10, the Q10 coordinate typedef, and the state enum {IDLE,SETUP,EMIT}.
- The per-step Bresenham update (err, x, y, sx, sy, dx, dy → next err, x, y) is a natural combinational sub-module, bresenham_step. The FSM and handshake stay in line_raster_gen.

Test Plan:
1. Horizontal: A=(0,0), B=(0x1000,0), pix_ready=1.
   - Expect first pix_valid 2 cycles after the handshake.
   - pix_X=0x000,0x400,0x800,0xC00,0x1000, pix_Y=0; pix_last only on the 5th.
   - done pulses the next cycle.
2. Steep: A=(0,0), B=(2,5) integer (Q10 0x800,0x1400).
   - Expect integer sequence (0,0),(0,1),(1,2),(1,3),(2,4),(2,5): 6 pixels, last on (2,5).
3. Negative direction: A=(3,3), B=(0,0).
   - Expect (3,3),(2,2),(1,1),(0,0); sx=sy=-1.
4. Degenerate and fractional floor:
   - A=(0x5FF,0x1C00) and B=(0x400,0x1FFF) both floor to (1,7).
   - Expect a single pixel X=0x400, Y=0x1C00 with pix_last=1.
   - Also check A=B=(7,-2): X=0x1C00, Y=0x1FF800.
5. Backpressure on test 2: drop pix_ready for 3 cycles while pixel (0,1) is presented.
   - Expect outputs held stable and no pixel skipped or duplicated; the sequence is identical to test 2.
6. Reset mid-line: assert rst for 1 cycle during test 1 after the 2nd pixel.
   - Expect pix_valid=0 next cycle, no done, cmd_ready=1 once rst drops.
   - A new command then rasterizes correctly from its own A.
